// File: rtl/stall_controller.sv
// stall_controller: RAW-hazard and data-memory-wait stall control over an EX/MEM/WB scoreboard
module stall_controller #(
    parameter int REG_BITS    = 4,
    parameter int DEPTH       = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_readReg0,
    input  logic [REG_BITS-1:0] id_readReg1,
    input  logic                id_immediate,
    input  logic                id_write,
    input  logic [REG_BITS-1:0] id_writeReg,
    input  logic                id_ReadMem,
    input  logic                id_WriteMem,
    input  logic                mem_ready,
    output logic                stall,
    output logic                bubble,
    output logic                mem_busy,
    output logic                timeout
);
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DEPTH-1:0]    r_v, r_wr, r_mem;
    logic [REG_BITS-1:0] r_reg [DEPTH];
    logic                w_hazard, w_frozen, w_expire, w_load_wait;
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            w_hazard = w_hazard | (r_v[i] & r_wr[i] & ((r_reg[i] == id_readReg0) | (!id_immediate & (r_reg[i] == id_readReg1))));
        w_hazard = w_hazard & id_valid;
    end
    assign w_load_wait = r_v[1] & r_mem[1] & !mem_ready;
    assign w_expire    = (r_state == MEM_WAIT) & !mem_ready & (r_cnt == LAST);
    assign w_frozen    = r_state == MEM_WAIT ? !mem_ready & (r_cnt < LAST) : w_load_wait;
    assign stall       = w_hazard | w_frozen;
    assign bubble      = w_hazard & !w_frozen;
    assign mem_busy    = r_state == MEM_WAIT;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v       <= '0;
            r_state   <= RUN;
            r_cnt     <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= w_expire;
            if (!w_frozen) begin
                r_v   <= {r_v[DEPTH-2:0], id_valid & !w_hazard};
                r_wr  <= {r_wr[DEPTH-2:0], id_write};
                r_mem <= {r_mem[DEPTH-2:0], id_ReadMem | id_WriteMem};
                for (int i = DEPTH - 1; i > 0; i--)
                    r_reg[i] <= r_reg[i-1];
                r_reg[0] <= id_writeReg;
            end
            if (r_state == RUN) begin
                if (w_load_wait) begin
                    r_state <= MEM_WAIT;
                    r_cnt   <= '0;
                end
            end else if (mem_ready || w_expire)
                r_state <= RUN;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
